// File: rtl/osc_cal_pkg.sv
// rtl/osc_cal_pkg.sv - shared types for the ring oscillator frequency calibration
// Purpose: FSM state encoding, oscillator ctrl code type and its range, step direction.
// Ports: none (package).
package osc_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        COMPARE,
        DONE,
        FAIL
    } state_t;

    typedef logic [1:0] code_t;

    localparam code_t CODE_MIN = 2'd0;
    localparam code_t CODE_MAX = 2'd3;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } step_t;

endpackage

// File: rtl/osc_freq_cal_if.sv
// rtl/osc_freq_cal_if.sv - config/status bus between register block and calibration controller
// Purpose: groups the run request and the calibration result signals.
// Ports (master = register block, slave = controller):
//   start, target_cnt         master -> slave
//   busy, locked, fail, meas_cnt  slave -> master
interface osc_freq_cal_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] target_cnt;
    logic             busy;
    logic             locked;
    logic             fail;
    logic [CNT_W-1:0] meas_cnt;

    modport master (
        output start, target_cnt,
        input  busy, locked, fail, meas_cnt
    );

    modport slave (
        input  start, target_cnt,
        output busy, locked, fail, meas_cnt
    );
endinterface

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - 2-flop synchronizer with registered rising-edge pulse
// Purpose: brings one oscillator phase into the clk domain and flags its rising edges.
// Ports: clk, rst (sync, active-high), tick (asynchronous input),
//        pulse (one clk high, 3 clk after the rising edge of tick).
module osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic pulse
);
    // sh[0], sh[1] form the synchronizer; sh[2] is the previous synchronized value.
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh    <= '0;
            pulse <= 1'b0;
        end else begin
            sh    <= {sh[1:0], tick};
            pulse <= sh[1] & ~sh[2];
        end
    end
endmodule

// File: rtl/osc_freq_cal.sv
// rtl/osc_freq_cal.sv - closed-loop frequency calibration controller for the ring oscillator
// Purpose: steps the oscillator ctrl code until the edge count per window matches the target.
// Ports: clk, rst (sync, active-high), osc_tick (divided oscillator phase, async),
//        ctrl (oscillator code, higher = slower), bus (config/status, slave side).
module osc_freq_cal
    import osc_cal_pkg::*;
#(
    parameter int          CNT_W         = 16,
    parameter int          WIN_CYCLES    = 1024,
    parameter int          SETTLE_CYCLES = 64,
    parameter int          TOL           = 2,
    parameter int          MAX_ITER      = 8,
    parameter logic [1:0]  INIT_CODE     = 2'b00
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           osc_tick,
    output code_t          ctrl,
    osc_freq_cal_if.slave  bus
);
    localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int ITER_W  = $clog2(MAX_ITER + 1);
    localparam int ERR_W   = CNT_W + 1;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   target_q;
    logic [ITER_W-1:0]  iter;
    step_t              prev_step;
    logic [ERR_W-1:0]   prev_abs_err;
    logic               busy_q;
    logic               locked_q;
    logic               fail_q;
    logic [CNT_W-1:0]   meas_q;
    logic               edge_pulse;

    logic [ERR_W-1:0]   err;
    logic [ERR_W-1:0]   abs_err;
    step_t              want;

    osc_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .tick  (osc_tick),
        .pulse (edge_pulse)
    );

    // Two's-complement difference in one extra bit; a positive error means the
    // oscillator runs too fast and needs a longer-period (higher) code.
    always_comb begin
        err     = {1'b0, edge_cnt} - {1'b0, target_q};
        abs_err = err[ERR_W-1] ? (~err + 1'b1) : err;
        if (abs_err <= ERR_W'(TOL)) begin
            want = NONE;
        end else if (err[ERR_W-1]) begin
            want = DOWN;
        end else begin
            want = UP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ctrl         <= INIT_CODE;
            tmr          <= '0;
            edge_cnt     <= '0;
            target_q     <= '0;
            iter         <= '0;
            prev_step    <= NONE;
            prev_abs_err <= '0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            meas_q       <= '0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (bus.start) begin
                        target_q  <= bus.target_cnt;
                        ctrl      <= INIT_CODE;
                        iter      <= '0;
                        prev_step <= NONE;
                        locked_q  <= 1'b0;
                        fail_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        tmr       <= '0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                        tmr      <= '0;
                        edge_cnt <= '0;
                        state    <= MEASURE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                MEASURE: begin
                    if (edge_pulse && (edge_cnt != {CNT_W{1'b1}})) begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                    if (tmr == TMR_W'(WIN_CYCLES - 1)) begin
                        tmr   <= '0;
                        state <= COMPARE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                COMPARE: begin
                    meas_q <= edge_cnt;
                    iter   <= iter + 1'b1;
                    if (want == NONE) begin
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end else if ((prev_step != NONE) && (want != prev_step)) begin
                        // Overshot: keep whichever of the last two codes was closer.
                        if (prev_abs_err < abs_err) begin
                            ctrl <= (prev_step == UP) ? ctrl - 2'd1 : ctrl + 2'd1;
                        end
                        locked_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end else if (((want == UP) && (ctrl == CODE_MAX)) ||
                                 ((want == DOWN) && (ctrl == CODE_MIN))) begin
                        fail_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= FAIL;
                    end else if (iter == ITER_W'(MAX_ITER - 1)) begin
                        fail_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= FAIL;
                    end else begin
                        ctrl         <= (want == UP) ? ctrl + 2'd1 : ctrl - 2'd1;
                        prev_step    <= want;
                        prev_abs_err <= abs_err;
                        tmr          <= '0;
                        state        <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.locked   = locked_q;
    assign bus.fail     = fail_q;
    assign bus.meas_cnt = meas_q;
endmodule
